// File: rtl/shift_compute_sequencer.sv
// Serialises a command operand LSB-first onto the compute-stage input byte,
// optionally followed by a single add/and latch cycle.
module shift_compute_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [7:0]       ui_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       sel_q;
    logic             add_q;
    logic             and_q;
    logic [7:0]       ui_in_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    assign cmd_ready = ready_q;
    assign ui_in     = ui_in_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // cnt_q counts bits already driven; bit 0 goes out in the accept edge,
    // so the last SHIFT cycle is the one where cnt_q reaches WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            add_q   <= 1'b0;
            and_q   <= 1'b0;
            ui_in_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid) begin
                        state_q <= SHIFT;
                        cnt_q   <= 4'd1;
                        data_q  <= cmd_data >> 1;
                        sel_q   <= cmd_sel;
                        add_q   <= (cmd_op == 2'b01);
                        and_q   <= (cmd_op == 2'b10);
                        ui_in_q <= {4'b0000, cmd_sel, cmd_data[0]};
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_q == 4'(WIDTH)) begin
                        if (add_q || and_q) begin
                            state_q <= LATCH;
                            ui_in_q <= {2'b00, and_q, add_q, sel_q, 1'b0};
                        end else begin
                            state_q <= IDLE;
                            ui_in_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        data_q  <= data_q >> 1;
                        ui_in_q <= {4'b0000, sel_q, data_q[0]};
                    end
                end
                LATCH: begin
                    state_q <= IDLE;
                    ui_in_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ui_in_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_compute_sequencer.md
SHIFT_COMPUTE_SEQUENCER -- requirements
Module: shift_compute_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand bit count serialized per command; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  2  00 shift only; 01 shift then latch_add; 10 shift then latch_and; 11 treated as 00.
REQ-007 cmd_sel  input  3  register select driven to the compute stage for the whole sequence.
REQ-008 cmd_data  input  WIDTH  operand, serialized LSB first.
REQ-009 ui_in  output  8  compute-stage input byte: {2'b00, latch_and, latch_add, select[2:0], data_in}.
REQ-010 busy  output  1  high while a sequence is being driven (SHIFT or LATCH).
REQ-011 done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-012 States: IDLE, SHIFT, LATCH; all outputs registered, no combinational input-to-output path except none permitted.
REQ-013 IDLE: cmd_ready=1, busy=0, ui_in=8'h00.
REQ-014 Handshake: command accepted on rising edge where cmd_valid=1 and cmd_ready=1; cmd_op, cmd_sel, cmd_data captured at that edge; later input changes ignored.
REQ-015 cmd_ready=0 in SHIFT and LATCH; cmd_valid ignored there.
REQ-016 Accept at edge of cycle k -> SHIFT occupies cycles k+1..k+WIDTH; in cycle k+i, ui_in[0]=captured data bit i-1, ui_in[3:1]=captured sel, ui_in[5:4]=0.
REQ-017 Shift bit counter 4 bits; SHIFT exits after exactly WIDTH cycles, no wrap or extra bit.
REQ-018 After SHIFT with op 01/10: LATCH for exactly one cycle (k+WIDTH+1); ui_in[0]=0, ui_in[3:1]=sel, ui_in[4]=1 for op 01, ui_in[5]=1 for op 10; never both.
REQ-019 After SHIFT with op 00/11: straight to IDLE, no latch cycle.
REQ-020 done=1 exactly in the first IDLE cycle after the last driven cycle; 0 otherwise.
REQ-021 Accept allowed in the done cycle; back-to-back sequences separated by exactly one all-zero ui_in cycle.
REQ-022 ui_in[7:6]=0 in every state.
REQ-023 busy=1 in every SHIFT and LATCH cycle.

Reset
REQ-024 rst=1 forces immediately, without waiting for clk: state IDLE, counter 0, ui_in=8'h00, busy=0, done=0, cmd_ready=1.
REQ-025 rst asserted mid-sequence aborts it; no latch pulse and no done pulse for the aborted command.
REQ-026 No command accepted while rst=1; first accept possible on first rising edge after rst deasserts.

Verification
REQ-027 Reset: rst=1 at any time -> ui_in=8'h00, cmd_ready=1, busy=0, done=0 before next clk edge.
REQ-028 Shift only: accept op=00 sel=3 data=8'hA5 at cycle k -> ui_in k+1..k+8 = 07,06,07,06,06,07,06,07; done=1 at k+9; no latch bit ever set.
REQ-029 Add: accept op=01 sel=0 data=8'h01 -> ui_in k+1=01, k+2..k+8=00, k+9=10, done=1 at k+10.
REQ-030 AND: accept op=10 sel=7 data=8'hFF -> ui_in=0F for k+1..k+8, k+9=2E, done=1 at k+10; cmd_valid pulses during k+1..k+9 not accepted.
REQ-031 Back-to-back: cmd_valid held with op=00 sel=1 data=8'h02 after an op=01 command -> second accepted in done cycle d; ui_in d=00, d+1=02, d+2=03.
REQ-032 Abort: op=01 data=8'hFF, rst pulsed during k+4 -> ui_in=00 immediately, no 10 latch cycle, no done; next op=00 data=8'h01 sequences normally.
